// File: rtl/pulse_channel_arbiter.sv
// Round-robin arbiter that funnels sticky per-source event requests into one
// shared pulse-synchronizer channel, spacing pulses by a gap and optional ack.
module pulse_channel_arbiter #(
    parameter int N      = 4,
    parameter int GAP    = 3,
    parameter bit ACK_EN = 1'b1,
    parameter int IDW    = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req_i,
    input  logic           ack_i,
    input  logic           clr_ovf_i,
    output logic           pulse_o,
    output logic [IDW-1:0] id_o,
    output logic           busy_o,
    output logic [N-1:0]   pending_o,
    output logic [N-1:0]   overflow_o
);

    localparam int CW = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_HOLD,
        S_WAIT_ACK
    } state_t;

    state_t         state_q;
    logic [CW-1:0]  cnt_q;
    logic [IDW-1:0] last_q;
    logic [IDW-1:0] id_q;
    logic           pulse_q;
    logic           busy_q;
    logic           ack_lat_q;
    logic [N-1:0]   pending_q;
    logic [N-1:0]   overflow_q;

    logic           found;
    logic [IDW-1:0] win;
    logic [N-1:0]   grant_clr;
    logic [N-1:0]   pending_d;
    logic [N-1:0]   overflow_d;

    // Search starts one past the last winner and wraps, giving round-robin order.
    always_comb begin
        int idx;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int i = 1; i <= N; i++) begin
            idx = int'(last_q) + i;
            if (idx >= N) idx = idx - N;
            if (!found && pending_q[IDW'(idx)]) begin
                found = 1'b1;
                win   = IDW'(idx);
            end
        end
    end

    always_comb begin
        grant_clr = '0;
        if (state_q == S_IDLE && found) grant_clr = N'(1) << win;
        pending_d  = (pending_q & ~grant_clr) | req_i;
        overflow_d = (clr_ovf_i ? '0 : overflow_q) | (req_i & pending_q & ~grant_clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            last_q     <= IDW'(N - 1);
            id_q       <= '0;
            pulse_q    <= 1'b0;
            busy_q     <= 1'b0;
            ack_lat_q  <= 1'b0;
            pending_q  <= '0;
            overflow_q <= '0;
        end else begin
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            pulse_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (found) begin
                        state_q <= S_ISSUE;
                        id_q    <= win;
                        last_q  <= win;
                        pulse_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    state_q <= S_HOLD;
                    cnt_q   <= CW'(GAP - 1);
                end
                S_HOLD: begin
                    ack_lat_q <= ack_lat_q | ack_i;
                    if (cnt_q == '0) begin
                        // An ack on the final hold cycle counts as already latched.
                        if (!ACK_EN || ack_lat_q || ack_i) begin
                            state_q   <= S_IDLE;
                            busy_q    <= 1'b0;
                            ack_lat_q <= 1'b0;
                        end else begin
                            state_q <= S_WAIT_ACK;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_WAIT_ACK: begin
                    if (ack_i) begin
                        state_q   <= S_IDLE;
                        busy_q    <= 1'b0;
                        ack_lat_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign pulse_o    = pulse_q;
    assign id_o       = id_q;
    assign busy_o     = busy_q;
    assign pending_o  = pending_q;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_pulse_channel_arbiter.sv
// Directed bench: dut0 runs gap-only (ACK_EN=0), dut1 waits for ack (ACK_EN=1).
module tb_pulse_channel_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req0, req1;
    logic       ack0, ack1, clr0, clr1;
    logic       pulse0, pulse1, busy0, busy1;
    logic [1:0] id0, id1;
    logic [3:0] pend0, pend1, ovf0, ovf1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pulse_channel_arbiter #(.N(4), .GAP(3), .ACK_EN(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .req_i(req0), .ack_i(ack0), .clr_ovf_i(clr0),
        .pulse_o(pulse0), .id_o(id0), .busy_o(busy0), .pending_o(pend0), .overflow_o(ovf0)
    );

    pulse_channel_arbiter #(.N(4), .GAP(3), .ACK_EN(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .req_i(req1), .ack_i(ack1), .clr_ovf_i(clr1),
        .pulse_o(pulse1), .id_o(id1), .busy_o(busy1), .pending_o(pend1), .overflow_o(ovf1)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // After return the bench sits in cycle 0 with reset released.
    task automatic do_reset();
        rst = 1'b1;
        req0 = '0; req1 = '0; ack0 = 1'b0; ack1 = 1'b0; clr0 = 1'b0; clr1 = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic scn_ack(input int a0, input int a1, input int idle_at);
        do_reset();
        for (int t = 0; t <= idle_at + 2; t++) begin
            check_val($sformatf("ack%0d busy t=%0d", a0, t), 32'(busy1), 32'(t >= 12 && t < idle_at));
            check_val($sformatf("ack%0d pulse t=%0d", a0, t), 32'(pulse1), 32'(t == 12));
            req1 = (t == 10) ? 4'b0001 : 4'b0000;
            ack1 = (t == a0 || t == a1);
            step();
        end
    endtask

    initial begin
        // single request, gap only
        do_reset();
        check_val("rst id", 32'(id0), 0);
        check_val("rst pend", 32'(pend0), 0);
        check_val("rst ovf", 32'(ovf0), 0);
        check_val("rst busy", 32'(busy0), 0);
        for (int t = 0; t <= 20; t++) begin
            check_val($sformatf("A pulse t=%0d", t), 32'(pulse0), 32'(t == 12));
            check_val($sformatf("A busy t=%0d", t), 32'(busy0), 32'(t >= 12 && t <= 15));
            if (t == 11) check_val("A pend t=11", 32'(pend0), 4);
            if (t >= 12) check_val($sformatf("A pend t=%0d", t), 32'(pend0), 0);
            if (t == 12 || t == 20) check_val($sformatf("A id t=%0d", t), 32'(id0), 2);
            req0 = (t == 10) ? 4'b0100 : 4'b0000;
            step();
        end

        // all sources at once: round-robin 0..3, one pulse per GAP+2 cycles
        do_reset();
        for (int t = 0; t <= 30; t++) begin
            check_val($sformatf("B pulse t=%0d", t), 32'(pulse0),
                      32'(t == 12 || t == 17 || t == 22 || t == 27));
            if (t == 12 || t == 17 || t == 22 || t == 27)
                check_val($sformatf("B id t=%0d", t), 32'(id0), 32'((t - 12) / 5));
            if (t == 11) check_val("B pend t=11", 32'(pend0), 15);
            if (t == 12) check_val("B pend t=12", 32'(pend0), 14);
            req0 = (t == 10) ? 4'b1111 : 4'b0000;
            step();
        end
        check_val("B ovf", 32'(ovf0), 0);

        // ack path: WAIT_ACK until ack at 20, second source issued at 22
        do_reset();
        for (int t = 0; t <= 24; t++) begin
            check_val($sformatf("C pulse t=%0d", t), 32'(pulse1), 32'(t == 12 || t == 22));
            check_val($sformatf("C busy t=%0d", t), 32'(busy1), 32'((t >= 12 && t <= 20) || t >= 22));
            if (t == 12) check_val("C id t=12", 32'(id1), 0);
            if (t == 22) check_val("C id t=22", 32'(id1), 1);
            req1 = (t == 10) ? 4'b0011 : 4'b0000;
            ack1 = (t == 20);
            step();
        end

        scn_ack(13, -1, 16);   // ack during HOLD is latched
        scn_ack(15, -1, 16);   // ack on the last HOLD cycle
        scn_ack(11, 20, 21);   // ack in IDLE ignored, waits for the one at 20

        // request coinciding with its own grant: stays pending, no overflow
        do_reset();
        for (int t = 0; t <= 18; t++) begin
            if (t == 12) begin
                check_val("E1 pulse t=12", 32'(pulse0), 1);
                check_val("E1 id t=12", 32'(id0), 1);
                check_val("E1 pend t=12", 32'(pend0), 2);
                check_val("E1 ovf t=12", 32'(ovf0), 0);
            end
            if (t == 17) begin
                check_val("E1 pulse t=17", 32'(pulse0), 1);
                check_val("E1 id t=17", 32'(id0), 1);
                check_val("E1 pend t=17", 32'(pend0), 0);
            end
            req0 = (t == 10 || t == 11) ? 4'b0010 : 4'b0000;
            step();
        end

        // overflow while busy, clear, and set-wins-over-clear
        do_reset();
        for (int t = 0; t <= 22; t++) begin
            if (t == 13) check_val("E2 pend t=13", 32'(pend0), 2);
            if (t == 13) check_val("E2 ovf t=13", 32'(ovf0), 0);
            if (t == 14) check_val("E2 ovf t=14", 32'(ovf0), 2);
            if (t == 17) check_val("E2 id t=17", 32'(id0), 1);
            if (t == 17) check_val("E2 pulse t=17", 32'(pulse0), 1);
            if (t == 20) check_val("E2 ovf t=20", 32'(ovf0), 2);
            if (t == 21) check_val("E2 ovf t=21", 32'(ovf0), 4);
            case (t)
                10:      req0 = 4'b0001;
                12, 13:  req0 = 4'b0010;
                18, 20:  req0 = 4'b0100;
                default: req0 = 4'b0000;
            endcase
            clr0 = (t == 20);
            step();
        end

        // reset during ISSUE discards pending work and restores priority
        do_reset();
        for (int t = 0; t <= 30; t++) begin
            if (t == 13) begin
                check_val("F pulse t=13", 32'(pulse0), 0);
                check_val("F id t=13", 32'(id0), 0);
                check_val("F busy t=13", 32'(busy0), 0);
                check_val("F pend t=13", 32'(pend0), 0);
                check_val("F ovf t=13", 32'(ovf0), 0);
            end
            if (t >= 13 && t <= 29) check_val($sformatf("F pulse t=%0d", t), 32'(pulse0), 32'(t == 28));
            if (t == 28) check_val("F id t=28", 32'(id0), 0);
            rst  = (t == 12);
            req0 = (t == 10 || t == 26) ? 4'b1111 : 4'b0000;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
